pe_mac_param: RTL

PE_MAC_PARAM -- requirements
Module: pe_mac_param

---
 rtl/pe_mac_param_if.sv | 37 +++
 rtl/pe_mac_param.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pe_mac_param_if.sv
// Bundles the north/west inputs and south/east outputs of one processing element.
interface pe_mac_param_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
);
  logic              en;
  logic              mode;
  logic [ACC_W-1:0]  psum_in;
  logic [DATA_W-1:0] weight_in;
  logic              accept_w_in;
  logic [DATA_W-1:0] input_in;
  logic              valid_in;
  logic              switch_in;
  logic              drain_in;
  logic              ovf_clr;
  logic [ACC_W-1:0]  psum_out;
  logic [DATA_W-1:0] weight_out;
  logic [DATA_W-1:0] input_out;
  logic              valid_out;
  logic              switch_out;
  logic              drain_out;
  logic              ovf;

  modport master (
    output en, mode, psum_in, weight_in, accept_w_in, input_in,
           valid_in, switch_in, drain_in, ovf_clr,
    input  psum_out, weight_out, input_out, valid_out, switch_out,
           drain_out, ovf
  );

  modport slave (
    input  en, mode, psum_in, weight_in, accept_w_in, input_in,
           valid_in, switch_in, drain_in, ovf_clr,
    output psum_out, weight_out, input_out, valid_out, switch_out,
           drain_out, ovf
  );
endinterface

// File: rtl/pe_mac_param.sv
// Systolic-array MAC processing element, weight-stationary or
// output-stationary, with optional saturation and a sticky overflow flag.
module pe_mac_param #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int SAT_EN = 1
) (
  input logic           clk,
  input logic           rst_n,
  pe_mac_param_if.slave bus
);

  localparam int PW = 2 * DATA_W;

  // Registered state
  logic [DATA_W-1:0] r_w_shadow, r_w_active;
  logic [ACC_W-1:0]  r_acc, r_psum_out;
  logic [DATA_W-1:0] r_weight_out, r_input_out;
  logic              r_valid_out, r_switch_out, r_drain_out, r_ovf;

  // Datapath and next-state wires
  logic [DATA_W-1:0] w_w_eff, w_mul_b;
  logic [PW-1:0]     w_a_ext, w_b_ext, w_prod;
  logic [ACC_W-1:0]  w_addend, w_mac;
  logic [ACC_W:0]    w_prod_ext, w_sum;
  logic              w_ovf_evt;
  logic [DATA_W-1:0] w_shadow_nxt, w_active_nxt, w_weight_nxt, w_input_nxt;
  logic [ACC_W-1:0]  w_acc_nxt, w_psum_nxt;
  logic              w_ovf_nxt;

  // Clamp (or wrap) an ACC_W+1 bit sum into ACC_W bits.
  function automatic logic [ACC_W-1:0] f_sat(input logic [ACC_W:0] s);
    logic [ACC_W-1:0] v;
    if ((SAT_EN != 0) && (s[ACC_W] != s[ACC_W-1])) begin
      if (s[ACC_W]) v = {1'b1, {(ACC_W-1){1'b0}}};
      else          v = {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      v = s[ACC_W-1:0];
    end
    return v;
  endfunction

  // A weight arriving together with switch_in is already the promoted one.
  assign w_w_eff  = bus.switch_in ? r_w_shadow : r_w_active;
  assign w_mul_b  = bus.mode ? bus.weight_in : w_w_eff;
  // OS drain with valid starts a new tile, so the accumulator addend is zero.
  assign w_addend = bus.mode ? (bus.drain_in ? {ACC_W{1'b0}} : r_acc) : bus.psum_in;

  // Low PW bits of a product of sign-extended operands equal the signed product.
  assign w_a_ext    = {{DATA_W{bus.input_in[DATA_W-1]}}, bus.input_in};
  assign w_b_ext    = {{DATA_W{w_mul_b[DATA_W-1]}}, w_mul_b};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_ext = {{(ACC_W+1-PW){w_prod[PW-1]}}, w_prod};
  assign w_sum      = {w_addend[ACC_W-1], w_addend} + w_prod_ext;
  assign w_mac      = f_sat(w_sum);
  assign w_ovf_evt  = bus.valid_in & (w_sum[ACC_W] ^ w_sum[ACC_W-1]);

  // Next-state selection for weights, accumulator and forwarded data.
  always_comb begin
    w_shadow_nxt = r_w_shadow;
    w_active_nxt = r_w_active;
    w_acc_nxt    = r_acc;
    w_psum_nxt   = {ACC_W{1'b0}};
    w_weight_nxt = {DATA_W{1'b0}};
    w_input_nxt  = bus.valid_in ? bus.input_in : r_input_out;
    w_ovf_nxt    = w_ovf_evt | (r_ovf & ~bus.ovf_clr);
    if (!bus.mode) begin
      if (bus.accept_w_in) begin
        w_shadow_nxt = bus.weight_in;
        w_weight_nxt = bus.weight_in;
      end else begin
        w_weight_nxt = {DATA_W{1'b0}};
      end
      if (bus.switch_in) w_active_nxt = r_w_shadow;
      else               w_active_nxt = r_w_active;
      if (bus.valid_in) w_psum_nxt = w_mac;
      else              w_psum_nxt = {ACC_W{1'b0}};
    end else begin
      w_weight_nxt = bus.valid_in ? bus.weight_in : {DATA_W{1'b0}};
      w_psum_nxt   = bus.drain_in ? r_acc : bus.psum_in;
      case ({bus.drain_in, bus.valid_in})
        2'b01, 2'b11: w_acc_nxt = w_mac;
        2'b10:        w_acc_nxt = {ACC_W{1'b0}};
        default:      w_acc_nxt = r_acc;
      endcase
    end
  end

  // State and output registers; en low clears everything synchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_shadow   <= {DATA_W{1'b0}};
      r_w_active   <= {DATA_W{1'b0}};
      r_acc        <= {ACC_W{1'b0}};
      r_psum_out   <= {ACC_W{1'b0}};
      r_weight_out <= {DATA_W{1'b0}};
      r_input_out  <= {DATA_W{1'b0}};
      r_valid_out  <= 1'b0;
      r_switch_out <= 1'b0;
      r_drain_out  <= 1'b0;
      r_ovf        <= 1'b0;
    end else if (!bus.en) begin
      r_w_shadow   <= {DATA_W{1'b0}};
      r_w_active   <= {DATA_W{1'b0}};
      r_acc        <= {ACC_W{1'b0}};
      r_psum_out   <= {ACC_W{1'b0}};
      r_weight_out <= {DATA_W{1'b0}};
      r_input_out  <= {DATA_W{1'b0}};
      r_valid_out  <= 1'b0;
      r_switch_out <= 1'b0;
      r_drain_out  <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_w_shadow   <= w_shadow_nxt;
      r_w_active   <= w_active_nxt;
      r_acc        <= w_acc_nxt;
      r_psum_out   <= w_psum_nxt;
      r_weight_out <= w_weight_nxt;
      r_input_out  <= w_input_nxt;
      r_valid_out  <= bus.valid_in;
      r_switch_out <= bus.switch_in;
      r_drain_out  <= bus.drain_in;
      r_ovf        <= w_ovf_nxt;
    end
  end

  assign bus.psum_out   = r_psum_out;
  assign bus.weight_out = r_weight_out;
  assign bus.input_out  = r_input_out;
  assign bus.valid_out  = r_valid_out;
  assign bus.switch_out = r_switch_out;
  assign bus.drain_out  = r_drain_out;
  assign bus.ovf        = r_ovf;

endmodule
